// File: rtl/disp_pkg.sv
// Shared constants and types for the display arbiter.
// Source numbering, blank mask and state codes.
package disp_pkg;

  localparam int NUM_SRC   = 3;
  localparam int SRC_RSG   = 0;
  localparam int SRC_PAT   = 1;
  localparam int SRC_SCORE = 2;

  localparam logic [3:0] BLANK_ALL = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  typedef logic [NUM_SRC-1:0] src_vec_t;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blank;
  } disp_src_t;

  localparam disp_src_t DISP_IDLE = '{
    dig:   16'h0000,
    blank: BLANK_ALL
  };

endpackage

// File: rtl/disp_hold_timer.sv
// Minimum-grant hold counter.
// Load beats Tick; decrements saturate at zero.
module disp_hold_timer #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [HOLD_W-1:0] load_val_i,
  input  logic              tick_i,
  output logic              zero_o
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  // Next count: load wins, else tick down, never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/disp_arbiter.sv
// Fixed-priority owner of the scanned 4-digit display.
// Grants hold for MIN_HOLD ticks, then may be preempted.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int MIN_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Tick,
  input  logic [2:0]   Req,
  input  logic [15:0]  Dig0,
  input  logic [15:0]  Dig1,
  input  logic [15:0]  Dig2,
  input  logic [3:0]   Blank0,
  input  logic [3:0]   Blank1,
  input  logic [3:0]   Blank2,
  output logic [3:0]   A,
  output logic [3:0]   B,
  output logic [3:0]   C,
  output logic [3:0]   D,
  output logic [3:0]   blank,
  output logic [2:0]   Gnt,
  output logic         Busy
);

  localparam logic [HOLD_W-1:0] HOLD_VAL =
    HOLD_W'(MIN_HOLD);

  src_vec_t  gnt_q;
  src_vec_t  gnt_d;
  src_vec_t  arb;
  logic [1:0] st;
  logic      load;
  logic      hold_zero;
  disp_src_t sel;
  disp_src_t out_q;

  // Lowest set request index wins.
  always_comb begin
    arb = '0;
    priority case (1'b1)
      Req[SRC_RSG]:   arb[SRC_RSG]   = 1'b1;
      Req[SRC_PAT]:   arb[SRC_PAT]   = 1'b1;
      Req[SRC_SCORE]: arb[SRC_SCORE] = 1'b1;
      default:        arb            = '0;
    endcase
  end

  // State is implied by the grant and the hold counter.
  always_comb begin
    if (gnt_q == '0) begin
      st = ST_IDLE;
    end else if (!hold_zero) begin
      st = ST_HOLD;
    end else begin
      st = ST_OWN;
    end
  end

  // Grant transitions; a change of owner reloads the hold.
  always_comb begin
    gnt_d = gnt_q;
    load  = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (|Req) begin
          gnt_d = arb;
          load  = 1'b1;
        end
      end
      ST_HOLD: begin
        gnt_d = gnt_q;
      end
      ST_OWN: begin
        if (arb != gnt_q) begin
          gnt_d = arb;
          load  = |Req;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  // Grant register.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
    end
  end

  disp_hold_timer #(
    .HOLD_W (HOLD_W)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (HOLD_VAL),
    .tick_i     (Tick),
    .zero_o     (hold_zero)
  );

  // Live data of the current owner; dark when idle.
  always_comb begin
    sel = DISP_IDLE;
    unique case (1'b1)
      gnt_q[SRC_RSG]: begin
        sel.dig   = Dig0;
        sel.blank = Blank0;
      end
      gnt_q[SRC_PAT]: begin
        sel.dig   = Dig1;
        sel.blank = Blank1;
      end
      gnt_q[SRC_SCORE]: begin
        sel.dig   = Dig2;
        sel.blank = Blank2;
      end
      default: begin
        sel = DISP_IDLE;
      end
    endcase
  end

  // Output register feeding the digit scanner.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= DISP_IDLE;
    end else begin
      out_q <= sel;
    end
  end

  assign A     = out_q.dig[15:12];
  assign B     = out_q.dig[11:8];
  assign C     = out_q.dig[7:4];
  assign D     = out_q.dig[3:0];
  assign blank = out_q.blank;
  assign Gnt   = gnt_q;
  assign Busy  = |gnt_q;

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Time-shares the single 4-digit scanned display (Mux4Machine -> Hex27Seg) between three requesters: 0 = rdysetgo countdown, 1 = Simon pattern playback, 2 = score readout.
- Arbitration is fixed-priority (0 highest). A granted source is guaranteed a minimum on-screen time, counted in IncCounter ticks from ClockDivide.
- Outputs A, B, C, D and blank drive Mux4Machine directly.

Parameters:
- MIN_HOLD, 4: minimum grant duration in Tick pulses; 0 means no hold.
- HOLD_W, 4: width of the hold counter; MIN_HOLD must be <= 2^HOLD_W - 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- Tick  in  1  one-clk pulse from ClockDivide (IncCounter).
- Req  in  3  per-source request; bit i belongs to source i.
- Dig0, Dig1, Dig2  in  16 each  source digits {A,B,C,D}; A = [15:12], D = [3:0].
- Blank0, Blank1, Blank2  in  4 each  source blank mask; bit 3 = A … bit 0 = D; 1 = digit dark.
- A, B, C, D  out  4 each  selected digit nibbles, registered.
- blank  out  4  selected blank mask, registered.
- Gnt  out  3  one-hot grant, registered; 3'b000 when idle.
- Busy  out  1  equals |Gnt.

Behaviour:
- Reset: Gnt = 000, Busy = 0, hold counter = 0, A = B = C = D = 4'h0, blank = 4'hF. Reset asserted mid-grant returns to these values on the next edge; state is not retained.
- States:
  - IDLE (Gnt = 0).
  - HOLD: granted, hold counter > 0.
  - OWN: granted, hold counter = 0.
- Arbitration function ARB(Req) returns the lowest-index set bit, one-hot, or 000 if none.
- IDLE:
  - Req = 0: stay in IDLE.
  - Otherwise: next Gnt = ARB(Req) and the hold counter loads MIN_HOLD.
  - Next state is HOLD if MIN_HOLD > 0, else OWN.
- HOLD:
  - Grant is frozen. Dropping the owner's Req and higher-priority requests are both ignored.
  - Each Tick decrements the counter; moving to OWN happens when it reaches 0.
- OWN, evaluated every clk:
  - Owner Req low and Req = 0: go to IDLE, Gnt = 000.
  - Owner Req low and other reqs present: Gnt = ARB(Req), reload MIN_HOLD, go to HOLD (or OWN if MIN_HOLD = 0).
  - Owner Req high and a higher-priority Req high: preempt, Gnt = ARB(Req), reload.
  - Otherwise: keep the grant.
- A re-grant to a different source always reloads the hold counter. A Tick in the same cycle as a load is ignored, so the load wins.
- Latency:
  - Req rising at edge n gives Gnt at n+1.
  - A..D/blank are registered from the source selected by the current Gnt, so the new source's data appears at n+2.
  - While idle, A..D/blank output 0 / 4'hF one cycle after Gnt clears.
- Data path:
  - Source data is sampled every clk while granted, so live countdown updates pass through with 1 clk delay.
  - No data is latched at grant time.
- Gnt is always one-hot or zero; never more than one bit set.
- Tick while IDLE or OWN has no effect.
- Hold counter saturates at 0 and never wraps.

Decomposition:
- Shared package (disp_pkg):
  - NUM_SRC = 3.
  - Source indices SRC_RSG = 0, SRC_PAT = 1, SRC_SCORE = 2.
  - BLANK_ALL = 4'hF.
  - State encoding IDLE / HOLD / OWN.
- One sub-module, disp_hold_timer:
  - Inputs: load, load value, Tick.
  - Output: zero flag.
  - Implements load-over-Tick priority and saturation.
- Priority encoder and data mux stay inline.

Test Plan:
- Reset sequence: after reset, Gnt = 000, Busy = 0, blank = F, A..D = 0. Assert reset mid-HOLD → same values on the next edge.
- Single requester: Req = 001, Dig0 = 16'h1234, Blank0 = 0 → Gnt = 001 at n+1, A = 1, B = 2, C = 3, D = 4 at n+2. Drop Req after 4 Ticks → Gnt = 000 and blank = F, each one clk later.
- Minimum hold: Req = 001 for 1 clk only, MIN_HOLD = 4 → Gnt = 001 persists until exactly the 4th Tick, then Gnt = 000.
- Preemption: Req = 100 granted and hold expired, then Req = 101 → Gnt = 001 next clk and counter reloaded. The same Req during HOLD → no change until the hold expires.
- Handoff: owner 001 drops Req while Req[1] = 1 in OWN → Gnt = 010 next clk and Dig1 on outputs the clk after. Tick coinciding with the reload → counter = MIN_HOLD, not MIN_HOLD − 1.
- MIN_HOLD = 0 build: Req toggling 100 → 010 → 001 on consecutive clks → Gnt follows ARB each clk, always one-hot.
